cvp_mem_if: RTL

Memory-side bus interface between the CVP14 core bus (Addr/RD/WR/DataOut/DataIn) and a slower external SRAM/ROM with a req/ack handshake.
- Buffers core writes in a small posted-write FIFO.
- Serialises reads behind pending writes, so read ordering is preserved.
- Returns read data with a valid strobe.
- Raises Stall whenever it cannot accept a new request, and flags memory timeouts.

---
 rtl/cvp_mem_if_if.sv | 34 +++
 rtl/cvp_mem_if.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cvp_mem_if_if.sv
// cvp_mem_if_if: core-side and memory-side signals of the CVP14 memory bridge.
// master = environment (core + memory), slave = bridge.
interface cvp_mem_if_if;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic        RdValid;
  logic        Stall;
  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic [15:0] MemRData;
  logic        MemReq;
  logic        MemWE;
  logic        MemAck;
  logic        MemErr;

  modport master (
    output Addr, RD, WR, DataOut,
    output MemRData, MemAck,
    input  DataIn, RdValid, Stall,
    input  MemAddr, MemWData,
    input  MemReq, MemWE, MemErr
  );

  modport slave (
    input  Addr, RD, WR, DataOut,
    input  MemRData, MemAck,
    output DataIn, RdValid, Stall,
    output MemAddr, MemWData,
    output MemReq, MemWE, MemErr
  );
endinterface

// File: rtl/cvp_mem_if.sv
// cvp_mem_if: CVP14 core bus to req/ack external memory bridge.
// Posted writes drain ahead of a single outstanding read.
module cvp_mem_if #(
  parameter int WDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input logic         Clk1,
  input logic         Reset,
  cvp_mem_if_if.slave bus
);
  localparam int PW = $clog2(WDEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(WDEPTH);
  localparam logic [PW:0]   ONE_C    = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [7:0]    TO_CNT   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, RESP, ERR
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   waddr_q [WDEPTH];
  logic [15:0]   wdata_q [WDEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic [15:0]   raddr_q;
  logic          rd_pend_q;
  logic [15:0]   rdata_q;
  logic          err_q, err_d;
  logic [7:0]    to_q, to_d;

  logic        full, empty, stall;
  logic        push, take_rd, pop;
  logic        rsp_ld, rsp_done, to_hit;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign stall   = full | rd_pend_q | err_q;
  assign push    = bus.WR & ~stall;
  assign take_rd = bus.RD & ~stall;
  assign to_hit  = ((to_q + 8'd1) == TO_CNT);

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    err_d     = err_q;
    pop       = 1'b0;
    rsp_ld    = 1'b0;
    rsp_done  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        to_d = '0;
        if (!empty)         state_d = WRITE;
        else if (rd_pend_q) state_d = READ;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr_q[rptr_q];
        mem_wdata = wdata_q[rptr_q];
        if (bus.MemAck) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = raddr_q;
        if (bus.MemAck) begin
          rsp_ld  = 1'b1;
          state_d = RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      RESP: begin
        rsp_done = 1'b1;
        state_d  = IDLE;
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      to_q      <= '0;
      err_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      raddr_q   <= '0;
      rd_pend_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < WDEPTH; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      err_q   <= err_d;
      if (push) begin
        waddr_q[wptr_q] <= bus.Addr;
        wdata_q[wptr_q] <= bus.DataOut;
        wptr_q          <= wptr_q + ONE_P;
      end
      if (pop) rptr_q <= rptr_q + ONE_P;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + ONE_C;
        2'b01:   cnt_q <= cnt_q - ONE_C;
        default: cnt_q <= cnt_q;
      endcase
      // read latched with a same-cycle write is serviced after it
      if (take_rd) begin
        raddr_q   <= bus.Addr;
        rd_pend_q <= 1'b1;
      end else if (rsp_done) begin
        rd_pend_q <= 1'b0;
      end
      if (rsp_ld) rdata_q <= bus.MemRData;
    end
  end

  assign bus.DataIn   = rdata_q;
  assign bus.RdValid  = rsp_done;
  assign bus.Stall    = stall;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWData = mem_wdata;
  assign bus.MemReq   = mem_req;
  assign bus.MemWE    = mem_we;
  assign bus.MemErr   = err_q;
endmodule
